// File: rtl/team_11.sv
// 4x4 matrix keypad scanner with debounce and a 16-character right-justified ASCII line buffer.
// Define TEAM_11_BACKSPACE_EN to make the c2/r3 key act as backspace; otherwise that key is ignored.
module team_11 #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SCAN_SETTLE     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [3:0]   read_row,
    output logic [3:0]   scan_col,
    output logic [127:0] msg_1,
    output logic         key_valid,
    output logic [7:0]   key_ascii
);

`ifdef TEAM_11_BACKSPACE_EN
    localparam bit BKSP_EN = 1'b1;
`else
    localparam bit BKSP_EN = 1'b0;
`endif

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_SETTLE) ? DEBOUNCE_CYCLES : SCAN_SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [127:0] SPACES = {16{8'h20}};

    typedef enum logic [2:0] {IDLE, DEB_PRESS, SCAN, ACCEPT, DEB_RELEASE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     rows_meta_q, rows_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]     col_q, col_d;
    logic [3:0]     key_idx_q, key_idx_d;
    logic [127:0]   msg_q, msg_d;
    logic [4:0]     count_q, count_d;
    logic           key_valid_q, key_valid_d;
    logic [7:0]     key_ascii_q, key_ascii_d;
    logic [1:0]     row_sel;
    logic [7:0]     key_code;
    logic           is_clear, is_bksp;

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta_q <= 4'b0000;
            rows_q      <= 4'b0000;
            state_q     <= IDLE;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            key_idx_q   <= 4'd0;
            msg_q       <= SPACES;
            count_q     <= 5'd0;
            key_valid_q <= 1'b0;
            key_ascii_q <= 8'h00;
        end else begin
            rows_meta_q <= read_row;
            rows_q      <= rows_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_idx_q   <= key_idx_d;
            msg_q       <= msg_d;
            count_q     <= count_d;
            key_valid_q <= key_valid_d;
            key_ascii_q <= key_ascii_d;
        end
    end

    // Lowest asserted row wins when several rows are set in one column.
    always_comb begin
        row_sel = 2'd3;
        if (rows_q[0])      row_sel = 2'd0;
        else if (rows_q[1]) row_sel = 2'd1;
        else if (rows_q[2]) row_sel = 2'd2;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        key_idx_d = key_idx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                col_d = 2'd0;
                if (rows_q != 4'b0000) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (rows_q == 4'b0000) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCAN: begin
                if (cnt_q == CNT_W'(SCAN_SETTLE - 1)) begin
                    cnt_d = '0;
                    if (rows_q != 4'b0000) begin
                        key_idx_d = {col_q, row_sel};
                        state_d   = ACCEPT;
                    end else if (col_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACCEPT: begin
                state_d = DEB_RELEASE;
                cnt_d   = '0;
            end
            DEB_RELEASE: begin
                if (rows_q != 4'b0000) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Key index is {column, row}.
    always_comb begin
        key_code = 8'h00;
        is_clear = 1'b0;
        is_bksp  = 1'b0;
        case (key_idx_q)
            4'd0:  key_code = 8'h32;
            4'd1:  key_code = 8'h35;
            4'd2:  begin key_code = 8'h0C; is_clear = 1'b1; end
            4'd3:  key_code = 8'h30;
            4'd4:  key_code = 8'h31;
            4'd5:  key_code = 8'h34;
            4'd6:  key_code = 8'h37;
            4'd7:  key_code = 8'h38;
            4'd8:  key_code = 8'h33;
            4'd9:  key_code = 8'h36;
            4'd10: key_code = 8'h39;
            4'd11: begin key_code = 8'h08; is_bksp = 1'b1; end
            4'd12: key_code = 8'h2B;
            4'd13: key_code = 8'h2D;
            4'd14: key_code = 8'h2A;
            default: key_code = 8'h2F;
        endcase
    end

    always_comb begin
        msg_d       = msg_q;
        count_d     = count_q;
        key_ascii_d = key_ascii_q;
        key_valid_d = 1'b0;
        if (state_q == ACCEPT && en && !(is_bksp && !BKSP_EN)) begin
            key_valid_d = 1'b1;
            key_ascii_d = key_code;
            if (is_clear) begin
                msg_d   = SPACES;
                count_d = 5'd0;
            end else if (is_bksp) begin
                if (count_q != 5'd0) begin
                    msg_d   = {8'h20, msg_q[127:8]};
                    count_d = count_q - 5'd1;
                end
            end else if (count_q < 5'd16) begin
                msg_d   = {msg_q[119:0], key_code};
                count_d = count_q + 5'd1;
            end
        end
    end

    assign scan_col  = (state_q == SCAN) ? (4'b0001 << col_q) : 4'b1111;
    assign msg_1     = msg_q;
    assign key_valid = key_valid_q;
    assign key_ascii = key_ascii_q;

endmodule

// File: tb/tb_team_11.sv
// Self-checking bench for team_11: a keypad matrix model drives read_row from scan_col,
// and a queue-based line model predicts msg_1, key_ascii and key_valid.
module tb_team_11;
    localparam int DEB    = 40;
    localparam int SETTLE = 4;
`ifdef TEAM_11_BACKSPACE_EN
    localparam bit BKSP_EN = 1'b1;
`else
    localparam bit BKSP_EN = 1'b0;
`endif
    localparam logic [127:0] SPACES = {16{8'h20}};

    logic         clk, rst, en;
    logic [3:0]   read_row, scan_col;
    logic [127:0] msg_1;
    logic         key_valid;
    logic [7:0]   key_ascii;

    logic         key_down;
    logic [1:0]   key_col, key_row;
    logic [3:0]   glitch_rows;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_ascii;
    logic [7:0] key_map [16] = '{8'h32, 8'h35, 8'h0C, 8'h30, 8'h31, 8'h34, 8'h37, 8'h38,
                                 8'h33, 8'h36, 8'h39, 8'h08, 8'h2B, 8'h2D, 8'h2A, 8'h2F};

    team_11 #(.DEBOUNCE_CYCLES(DEB), .SCAN_SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .en(en), .read_row(read_row), .scan_col(scan_col),
        .msg_1(msg_1), .key_valid(key_valid), .key_ascii(key_ascii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column drive to its row line.
    always_comb begin
        read_row = glitch_rows;
        if (key_down && scan_col[key_col]) read_row = read_row | (4'b0001 << key_row);
    end

    function automatic int exp_lat(input int col);
        return 2 + DEB + (col + 1) * SETTLE + 1;
    endfunction

    function automatic logic [127:0] exp_msg();
        logic [127:0] m = SPACES;
        for (int i = 0; i < model_q.size() && i < 16; i++) m[8*i +: 8] = model_q[model_q.size()-1-i];
        return m;
    endfunction

    task automatic model_apply(input int idx, output bit pulse);
        logic [7:0] a = key_map[idx];
        pulse = 1'b1;
        if (a == 8'h08 && !BKSP_EN) begin
            pulse = 1'b0;
        end else begin
            exp_ascii = a;
            if (a == 8'h0C) model_q.delete();
            else if (a == 8'h08) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
            end else if (model_q.size() < 16) model_q.push_back(a);
        end
    endtask

    // Press, hold, release and wait out the release debounce, recording what was seen.
    task automatic do_press(input int col, input int row, input int hold, output int lat,
                            output int pulses, output logic [127:0] msg_at, output logic [7:0] ascii_at);
        lat = -1; pulses = 0; msg_at = msg_1; ascii_at = key_ascii;
        @(negedge clk);
        key_col = 2'(col); key_row = 2'(row); key_down = 1'b1;
        for (int c = 0; c < exp_lat(3) + hold; c++) begin
            @(posedge clk); #1;
            if (key_valid) begin
                pulses++;
                if (lat < 0) begin lat = c; msg_at = msg_1; ascii_at = key_ascii; end
            end
        end
        @(negedge clk);
        key_down = 1'b0;
        for (int c = 0; c < DEB + 10; c++) begin
            @(posedge clk); #1;
            if (key_valid) pulses++;
        end
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; en = 1'b0; key_down = 1'b0; glitch_rows = 4'b0000; key_col = 2'd0; key_row = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (msg_1 !== SPACES) begin tests_failed++; $display("[TB] FAIL reset_msg: got %h expected %h", msg_1, SPACES); end
        tests_run++; if (scan_col !== 4'b1111) begin tests_failed++; $display("[TB] FAIL reset_scan: got %b expected 1111", scan_col); end
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
        tests_run++; if (key_ascii !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_ascii: got %h expected 00", key_ascii); end
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        model_q.delete(); exp_ascii = 8'h00;
        for (int c = 0; c < 50; c++) begin @(posedge clk); #1; if (key_valid) pulses++; end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("[TB] FAIL idle_pulses: got %0d expected 0", pulses); end
        tests_run++; if (scan_col !== 4'b1111 || msg_1 !== SPACES) begin tests_failed++; $display("[TB] FAIL idle_state: got scan %b msg %h expected 1111 / spaces", scan_col, msg_1); end
    endtask

    task automatic test_hold_clear();
        int lat, pulses; logic [127:0] m; logic [7:0] a; bit p;
        model_apply(2, p);
        do_press(0, 2, 300, lat, pulses, m, a);
        tests_run++; if (pulses != 1) begin tests_failed++; $display("[TB] FAIL clear_pulses: got %0d expected 1", pulses); end
        tests_run++; if (a !== 8'h0C || m !== SPACES) begin tests_failed++; $display("[TB] FAIL clear_result: got %h/%h expected 0c/%h", a, m, SPACES); end
        model_apply(0, p);
        do_press(0, 0, 300, lat, pulses, m, a);
        tests_run++; if (pulses != 1) begin tests_failed++; $display("[TB] FAIL held2_pulses: got %0d expected 1", pulses); end
        tests_run++; if (lat != exp_lat(0)) begin tests_failed++; $display("[TB] FAIL held2_latency: got %0d expected %0d", lat, exp_lat(0)); end
        tests_run++; if (m !== {{15{8'h20}}, 8'h32} || a !== 8'h32) begin tests_failed++; $display("[TB] FAIL held2_result: got %h/%h expected 32/%h", a, m, {{15{8'h20}}, 8'h32}); end
    endtask

    task automatic test_fill();
        int lat, pulses; logic [127:0] m; logic [7:0] a; bit p;
        model_apply(2, p);
        do_press(0, 2, 10, lat, pulses, m, a);
        for (int i = 0; i < 17; i++) begin
            model_apply(4, p);
            do_press(1, 0, 10, lat, pulses, m, a);
            tests_run++; if (pulses != 1 || lat != exp_lat(1)) begin tests_failed++; $display("[TB] FAIL fill_pulse_%0d: got %0d pulses lat %0d expected 1 / %0d", i, pulses, lat, exp_lat(1)); end
            tests_run++; if (m !== exp_msg()) begin tests_failed++; $display("[TB] FAIL fill_msg_%0d: got %h expected %h", i, m, exp_msg()); end
        end
        tests_run++; if (msg_1 !== {16{8'h31}}) begin tests_failed++; $display("[TB] FAIL fill_full: got %h expected %h", msg_1, {16{8'h31}}); end
    endtask

    task automatic test_backspace();
        int lat, pulses; logic [127:0] m; logic [7:0] a; bit p;
        int seq [5] = '{2, 0, 1, 11, 2};
        for (int i = 0; i < 5; i++) begin
            model_apply(seq[i], p);
            do_press(seq[i] / 4, seq[i] % 4, 10, lat, pulses, m, a);
            tests_run++; if (pulses != int'(p)) begin tests_failed++; $display("[TB] FAIL bksp_pulses_%0d: got %0d expected %0d", i, pulses, int'(p)); end
            if (i == 3) begin
                tests_run++;
                if (msg_1 !== (BKSP_EN ? {{15{8'h20}}, 8'h32} : {{14{8'h20}}, 8'h32, 8'h35})) begin
                    tests_failed++; $display("[TB] FAIL bksp_msg: got %h (backspace enabled=%0d)", msg_1, BKSP_EN);
                end
            end
        end
        model_apply(11, p);
        do_press(2, 3, 10, lat, pulses, m, a);
        tests_run++; if (pulses != int'(p) || msg_1 !== SPACES || key_ascii !== exp_ascii) begin tests_failed++; $display("[TB] FAIL bksp_empty: got %0d pulses msg %h ascii %h expected %0d / spaces / %h", pulses, msg_1, key_ascii, int'(p), exp_ascii); end
    endtask

    task automatic test_glitch();
        int lat, pulses = 0; logic [127:0] m; logic [7:0] a; bit p;
        @(negedge clk); glitch_rows = 4'b0010;
        repeat (DEB / 2) @(posedge clk);
        @(negedge clk); glitch_rows = 4'b0000;
        for (int c = 0; c < DEB + 20; c++) begin @(posedge clk); #1; if (key_valid) pulses++; end
        tests_run++; if (pulses != 0 || scan_col !== 4'b1111) begin tests_failed++; $display("[TB] FAIL glitch: got %0d pulses scan %b expected 0 / 1111", pulses, scan_col); end
        model_apply(13, p);
        do_press(3, 1, 10, lat, pulses, m, a);
        tests_run++; if (pulses != 1 || lat != exp_lat(3)) begin tests_failed++; $display("[TB] FAIL post_glitch: got %0d pulses lat %0d expected 1 / %0d", pulses, lat, exp_lat(3)); end
        tests_run++; if (m !== exp_msg() || a !== exp_ascii) begin tests_failed++; $display("[TB] FAIL post_glitch_msg: got %h/%h expected %h/%h", m, a, exp_msg(), exp_ascii); end
    endtask

    task automatic test_en_drop();
        int pulses = 0;
        logic [127:0] held = msg_1;
        @(negedge clk); key_col = 2'd3; key_row = 2'd0; key_down = 1'b1;
        repeat (2 + DEB + 2) @(posedge clk);
        #1;
        tests_run++; if (scan_col !== 4'b0001) begin tests_failed++; $display("[TB] FAIL en_scan_mid: got %b expected 0001", scan_col); end
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (scan_col !== 4'b1111 || msg_1 !== held) begin tests_failed++; $display("[TB] FAIL en_drop: got scan %b msg %h expected 1111 / %h", scan_col, msg_1, held); end
        for (int c = 0; c < 100; c++) begin @(posedge clk); #1; if (key_valid) pulses++; end
        tests_run++; if (pulses != 0 || key_ascii !== exp_ascii || msg_1 !== exp_msg()) begin tests_failed++; $display("[TB] FAIL en_hold: got %0d pulses ascii %h msg %h expected 0 / %h / %h", pulses, key_ascii, msg_1, exp_ascii, exp_msg()); end
        @(negedge clk); key_down = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); en = 1'b1;
        repeat (DEB) @(posedge clk);
    endtask

    task automatic test_random();
        int lat, pulses, idx, hold; logic [127:0] m; logic [7:0] a; bit p;
        for (int i = 0; i < 24; i++) begin
            idx = int'($urandom_range(0, 15));
            hold = int'($urandom_range(10, 40));
            model_apply(idx, p);
            do_press(idx / 4, idx % 4, hold, lat, pulses, m, a);
            tests_run++; if (pulses != int'(p)) begin tests_failed++; $display("[TB] FAIL rand_pulses_%0d key %0d: got %0d expected %0d", i, idx, pulses, int'(p)); end
            if (p) begin
                tests_run++; if (lat != exp_lat(idx / 4)) begin tests_failed++; $display("[TB] FAIL rand_latency_%0d key %0d: got %0d expected %0d", i, idx, lat, exp_lat(idx / 4)); end
                tests_run++; if (m !== exp_msg() || a !== exp_ascii) begin tests_failed++; $display("[TB] FAIL rand_result_%0d key %0d: got %h/%h expected %h/%h", i, idx, m, a, exp_msg(), exp_ascii); end
            end else begin
                tests_run++; if (msg_1 !== exp_msg() || key_ascii !== exp_ascii) begin tests_failed++; $display("[TB] FAIL rand_ignored_%0d: got %h/%h expected %h/%h", i, msg_1, key_ascii, exp_msg(), exp_ascii); end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, pulses; logic [127:0] m; logic [7:0] a; bit p;
        @(negedge clk); key_col = 2'd2; key_row = 2'd1; key_down = 1'b1;
        repeat (2 + DEB + 2) @(posedge clk);
        #1;
        tests_run++; if (scan_col !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rst_scan_mid: got %b expected 0001", scan_col); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (msg_1 !== SPACES || scan_col !== 4'b1111 || key_valid !== 1'b0 || key_ascii !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL rst_mid: got msg %h scan %b valid %b ascii %h expected spaces / 1111 / 0 / 00", msg_1, scan_col, key_valid, key_ascii);
        end
        @(negedge clk); key_down = 1'b0; model_q.delete(); exp_ascii = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_apply(14, p);
        do_press(3, 2, 10, lat, pulses, m, a);
        tests_run++; if (pulses != 1 || lat != exp_lat(3) || m !== exp_msg()) begin tests_failed++; $display("[TB] FAIL post_rst: got %0d pulses lat %0d msg %h expected 1 / %0d / %h", pulses, lat, m, exp_lat(3), exp_msg()); end
    endtask

    initial begin
        test_reset();
        test_hold_clear();
        test_fill();
        test_backspace();
        test_glitch();
        test_en_drop();
        test_random();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
